rf_write_arbiter: RTL and testbench

//  Owns the single write port of the RISC-V register file (rf_riscv) and shares it between
//  N writeback requesters (ALU, LSU load-return, CSR) via valid/ready handshake.

---
 rtl/rf_arb_pkg.sv | 11 +
 rtl/rf_write_arbiter_if.sv | 29 ++
 rtl/rf_arb_core.sv | 69 ++++++
 rtl/rf_write_arbiter.sv | 104 ++++++++++
 tb/tb_rf_write_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Imported by the interface, the grant core and the top.
package rf_arb_pkg;

  typedef enum logic {CLEAR, RUN} rf_arb_state_t;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bus (N requesters) plus the single register-file write port.
// The arbiter uses the slave modport; requesters and the RF use master.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_wa;
  logic [DATA_W-1:0]       rf_wd;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_wa, rf_wd
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_wa, rf_wd
  );

endinterface

// File: rtl/rf_arb_core.sv
// N-way request -> one-hot grant plus winner index.
// RF_ARB_ROUND_ROBIN_EN selects round-robin (with pointer state); default is fixed priority.
module rf_arb_core #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
`ifdef RF_ARB_ROUND_ROBIN_EN
  input  logic             clk_i,
  input  logic             rst_i,
`endif
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!found && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      ptr_d = (int'(idx_o) == N_REQ - 1) ? '0 : idx_o + IDX_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && valid_i[k]) begin
        grant_o[k] = 1'b1;
        idx_o      = IDX_W'(k);
        found      = 1'b1;
      end
    end
  end
`endif

  assign any_o = |grant_o;

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: clears x1..x(NUM_REGS-1) after reset, then arbitrates
// writeback requesters. Arbitration policy set by RF_ARB_ROUND_ROBIN_EN (see rf_arb_core).
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  rf_write_arbiter_if.slave          arb_if,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_o
);

  localparam int IDX_W = $clog2(N_REQ);

  rf_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;

  logic [N_REQ-1:0]  arb_valid;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Requests are invisible to the arbiter until the clear sequence is done.
  assign arb_valid = (state_q == RUN) ? arb_if.req_valid : '0;

  rf_arb_core #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_core (
`ifdef RF_ARB_ROUND_ROBIN_EN
    .clk_i   (clk_i),
    .rst_i   (rst_i),
`endif
    .valid_i (arb_valid),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign win_addr = arb_if.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data = arb_if.req_data[int'(win_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    grant_idx_d = grant_idx_q;
    unique case (state_q)
      CLEAR: begin
        rf_we_d    = 1'b1;
        rf_wa_d    = clr_addr_q;
        rf_wd_d    = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(NUM_REGS - 1)) state_d = RUN;
      end
      RUN: begin
        if (win_any) begin
          // x0 writes are accepted so the requester can retire, but never reach the port.
          rf_we_d     = (win_addr != '0);
          rf_wa_d     = win_addr;
          rf_wd_d     = win_data;
          grant_idx_d = win_idx;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CLEAR;
      clr_addr_q  <= ADDR_W'(1);
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign arb_if.req_ready = grant;
  assign arb_if.rf_we     = rf_we_q;
  assign arb_if.rf_wa     = rf_wa_q;
  assign arb_if.rf_wd     = rf_wd_q;
  assign busy_o           = (state_q == CLEAR);
  assign grant_idx_o      = grant_idx_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register file behind the write port.
// Expectations follow RF_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_rf_write_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] gidx;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [DATA_W-1:0] rf_mem [32];

  rf_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .arb_if      (bus),
    .busy_o      (busy),
    .grant_idx_o (gidx)
  );

  always #5 clk = ~clk;

  // Register file stores every enabled write, x0 included, so a leaked x0 write is visible.
  always @(posedge clk) begin
    if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  logic [2:0] exp_rdy;
  int         win;

  initial begin
    rf_mem[0] = '0;
    for (int i = 1; i < 32; i++) rf_mem[i] = 32'hBAD0_0000 + 32'(i);
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    step();
    step();

    // Reset state
    check("rst_we",   32'(bus.rf_we), 32'd0);
    check("rst_wa",   32'(bus.rf_wa), 32'd0);
    check("rst_wd",   bus.rf_wd, 32'd0);
    check("rst_gidx", 32'(gidx), 32'd0);
    check("rst_rdy",  32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Test 1: clear sequence x1..x31, busy drops on first RUN cycle
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("clr_wa_%0d", k), 32'(bus.rf_wa), 32'(k));
      check("clr_we", 32'(bus.rf_we), 32'd1);
      check("clr_wd", bus.rf_wd, 32'd0);
      check($sformatf("clr_busy_%0d", k), 32'(busy), (k < 31) ? 32'd1 : 32'd0);
    end
    step();
    check("idle_we", 32'(bus.rf_we), 32'd0);
    for (int r = 1; r < 32; r++) check($sformatf("clr_x%0d", r), rf_mem[r], 32'd0);

    // Test 3: all requesters valid every cycle, distinct addresses
    set_req(0, 5'd10, 32'h0000_00A0);
    set_req(1, 5'd11, 32'h0000_00A1);
    set_req(2, 5'd12, 32'h0000_00A2);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      win = c % 3;
`else
      win = 0;
`endif
      exp_rdy = 3'b001 << win;
      #1;
      check($sformatf("all_rdy_%0d", c), 32'(bus.req_ready), 32'(exp_rdy));
      step();
      check($sformatf("all_wa_%0d", c), 32'(bus.rf_wa), 32'(10 + win));
      check($sformatf("all_gidx_%0d", c), 32'(gidx), 32'(win));
      check("all_we", 32'(bus.rf_we), 32'd1);
    end
    bus.req_valid = '0;
    step();
    check("no_acc_we", 32'(bus.rf_we), 32'd0);
    check("no_acc_wa_hold", 32'(bus.rf_wa), (win == 0) ? 32'd10 : 32'(10 + win));

    // Test 6: same address from requesters 0 and 2; last grant wins
    set_req(0, 5'd7, 32'h11);
    set_req(2, 5'd7, 32'h22);
    bus.req_valid = 3'b101;
    #1;
    check("same_rdy0", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = 3'b100;
    #1;
    check("same_rdy2", 32'(bus.req_ready), 32'b100);
    step();
    bus.req_valid = '0;
    check("same_x7_mid", rf_mem[7], 32'h11);
    step();
    check("same_x7_end", rf_mem[7], 32'h22);

    // Test 4: write to x0 is accepted but dropped
    set_req(1, 5'd0, 32'h1);
    bus.req_valid = 3'b010;
    #1;
    check("x0_rdy", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    check("x0_we", 32'(bus.rf_we), 32'd0);
    check("x0_gidx", 32'(gidx), 32'd1);
    step();
    check("x0_val", rf_mem[0], 32'd0);

    // Test 5: reset pulse mid-clear; Test 2: request pending through the clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    check("mid_wa9", 32'(bus.rf_wa), 32'd9);
    rst = 1'b1;
    step();
    check("mid_rst_we",   32'(bus.rf_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_gidx", 32'(gidx), 32'd0);
    rst = 1'b0;
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b001;
    #1;
    check("pend_rdy_start", 32'(bus.req_ready), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("re_wa_%0d", k), 32'(bus.rf_wa), 32'(k));
      check("re_we", 32'(bus.rf_we), 32'd1);
      check($sformatf("pend_rdy_%0d", k), 32'(bus.req_ready), (k == 31) ? 32'd1 : 32'd0);
    end
    step();
    bus.req_valid = '0;
    check("pend_wa", 32'(bus.rf_wa), 32'd5);
    check("pend_wd", bus.rf_wd, 32'hDEAD_BEEF);
    check("pend_we", 32'(bus.rf_we), 32'd1);
    check("re_x7_cleared", rf_mem[7], 32'd0);
    step();
    check("pend_x5", rf_mem[5], 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
